// File: rtl/pipe_stage_chain.sv
// Parametrised chain of valid-qualified pipeline registers with per-stage stall/flush,
// upstream stall propagation, downstream bubble insertion and saturating perf counters.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   In_Valid,
  input  logic [WIDTH-1:0]       In_Data,
  output logic                   In_Ready,
  input  logic [DEPTH-1:0]       Stall,
  input  logic [DEPTH-1:0]       Flush,
  output logic [DEPTH-1:0]       Stage_Valid,
  output logic [DEPTH*WIDTH-1:0] Stage_Data,
  output logic                   Out_Valid,
  output logic [WIDTH-1:0]       Out_Data,
  output logic [CNT_W-1:0]       Retire_Count,
  output logic [CNT_W-1:0]       Bubble_Count
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] bubble;
  logic             retire;
  logic             bubble_any;

  // hold[k] is set when stage k or anything downstream of it is stalled
  always_comb begin
    hold[DEPTH-1] = Stall[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) begin
      hold[k] = Stall[k] | hold[k+1];
    end
  end

  // A stalled-but-flushed stage releases its pre-edge entry downstream instead of a bubble
  always_comb begin
    bubble[0] = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      bubble[k] = Stall[k-1] & ~hold[k] & ~Flush[k-1] & ~Flush[k];
    end
  end

  assign In_Ready   = ~hold[0];
  assign retire     = Stage_Valid[DEPTH-1] & ~Stall[DEPTH-1];
  assign bubble_any = |bubble;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Stage_Valid <= '0;
      Stage_Data  <= '0;
    end else begin
      if (Flush[0]) begin
        Stage_Valid[0]         <= 1'b0;
        Stage_Data[0 +: WIDTH] <= '0;
      end else if (!hold[0]) begin
        Stage_Valid[0]         <= In_Valid;
        Stage_Data[0 +: WIDTH] <= In_Data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (Flush[k]) begin
          Stage_Valid[k]             <= 1'b0;
          Stage_Data[k*WIDTH +: WIDTH] <= '0;
        end else if (!hold[k]) begin
          if (Stall[k-1] && !Flush[k-1]) begin
            Stage_Valid[k]               <= 1'b0;
            Stage_Data[k*WIDTH +: WIDTH] <= '0;
          end else begin
            Stage_Valid[k]               <= Stage_Valid[k-1];
            Stage_Data[k*WIDTH +: WIDTH] <= Stage_Data[(k-1)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Retire_Count <= '0;
      Bubble_Count <= '0;
    end else begin
      if (retire && (Retire_Count != {CNT_W{1'b1}})) begin
        Retire_Count <= Retire_Count + CNT_W'(1);
      end
      if (bubble_any && (Bubble_Count != {CNT_W{1'b1}})) begin
        Bubble_Count <= Bubble_Count + CNT_W'(1);
      end
    end
  end

  assign Out_Valid = Stage_Valid[DEPTH-1];
  assign Out_Data  = Stage_Data[(DEPTH-1)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: reset, streaming, stall, flush, discard and
// counter saturation (second instance with a 3-bit counter).
module tb_pipe_stage_chain;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          In_Valid;
  logic [31:0]   In_Data;
  logic          In_Ready;
  logic [3:0]    Stall;
  logic [3:0]    Flush;
  logic [3:0]    Stage_Valid;
  logic [127:0]  Stage_Data;
  logic          Out_Valid;
  logic [31:0]   Out_Data;
  logic [15:0]   Retire_Count;
  logic [15:0]   Bubble_Count;

  logic          s_rst;
  logic          s_in_valid;
  logic [31:0]   s_in_data;
  logic          s_in_ready;
  logic [3:0]    s_stall = 4'b0;
  logic [3:0]    s_flush = 4'b0;
  logic [3:0]    s_stage_valid;
  logic [127:0]  s_stage_data;
  logic          s_out_valid;
  logic [31:0]   s_out_data;
  logic [2:0]    s_retire;
  logic [2:0]    s_bubble;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
    .Stall(Stall), .Flush(Flush), .Stage_Valid(Stage_Valid), .Stage_Data(Stage_Data),
    .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Retire_Count(Retire_Count), .Bubble_Count(Bubble_Count)
  );

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(3)) dut_sat (
    .Clk(Clk), .Rst(s_rst), .In_Valid(s_in_valid), .In_Data(s_in_data), .In_Ready(s_in_ready),
    .Stall(s_stall), .Flush(s_flush), .Stage_Valid(s_stage_valid), .Stage_Data(s_stage_data),
    .Out_Valid(s_out_valid), .Out_Data(s_out_data),
    .Retire_Count(s_retire), .Bubble_Count(s_bubble)
  );

  function automatic logic [31:0] sd(input int k);
    return Stage_Data[k*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1'b1; Stall = '0; Flush = '0; In_Valid = 1'b0; In_Data = '0;
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++; if (Stage_Valid !== 4'b0) begin miscompares++; $display("FAIL reset_valid got=%h exp=0", Stage_Valid); end
    vectors++; if (Stage_Data !== 128'b0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", Stage_Data); end
    vectors++; if (Retire_Count !== 16'd0) begin miscompares++; $display("FAIL reset_retire got=%0d exp=0", Retire_Count); end
    vectors++; if (Bubble_Count !== 16'd0) begin miscompares++; $display("FAIL reset_bubble got=%0d exp=0", Bubble_Count); end
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1'b1; In_Data = 32'(i + 1);
      tick();
    end
    In_Valid = 1'b0;
    vectors++; if (Stage_Valid !== 4'hF) begin miscompares++; $display("FAIL preload_valid got=%h exp=f", Stage_Valid); end
    vectors++; if (Out_Data !== 32'd1) begin miscompares++; $display("FAIL preload_out got=%h exp=1", Out_Data); end
    Rst = 1'b1; Stall = 4'hF; In_Valid = 1'b1; In_Data = 32'h55;
    tick();
    Rst = 1'b0; Stall = '0; In_Valid = 1'b0; In_Data = '0;
    vectors++; if (Stage_Valid !== 4'b0) begin miscompares++; $display("FAIL midrst_valid got=%h exp=0", Stage_Valid); end
    vectors++; if (Stage_Data !== 128'b0) begin miscompares++; $display("FAIL midrst_data got=%h exp=0", Stage_Data); end
    vectors++; if (Retire_Count !== 16'd0) begin miscompares++; $display("FAIL midrst_retire got=%0d exp=0", Retire_Count); end
    vectors++; if (Bubble_Count !== 16'd0) begin miscompares++; $display("FAIL midrst_bubble got=%0d exp=0", Bubble_Count); end
  endtask

  task automatic test_stream;
    logic        ev;
    logic [31:0] ed;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      In_Valid = (c < 3);
      In_Data  = (c < 3) ? 32'h11 * 32'(c + 1) : 32'h0;
      tick();
      ev = (c >= 3) && (c <= 5);
      ed = 32'h11 * 32'(c - 2);
      vectors++; if (Out_Valid !== ev) begin miscompares++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, Out_Valid, ev); end
      if (ev) begin
        vectors++; if (Out_Data !== ed) begin miscompares++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, Out_Data, ed); end
      end
    end
    In_Valid = 1'b0; In_Data = '0;
    vectors++; if (Retire_Count !== 16'd3) begin miscompares++; $display("FAIL stream_retire got=%0d exp=3", Retire_Count); end
    vectors++; if (Bubble_Count !== 16'd0) begin miscompares++; $display("FAIL stream_bubble got=%0d exp=0", Bubble_Count); end
  endtask

  task automatic test_mid_stall;
    logic [31:0] got[$];
    int          idx;
    logic        accept;
    logic        exp_rdy;
    do_reset();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      Stall    = (c == 3 || c == 4) ? 4'b0100 : 4'b0000;
      In_Valid = (idx < 6);
      In_Data  = 32'hA0 + 32'(idx);
      #1;
      exp_rdy = !(c == 3 || c == 4);
      vectors++; if (In_Ready !== exp_rdy) begin miscompares++; $display("FAIL stall_ready c=%0d got=%b exp=%b", c, In_Ready, exp_rdy); end
      accept = In_Ready && In_Valid;
      tick();
      if (accept) idx++;
      if (Out_Valid) got.push_back(Out_Data);
      if (c == 3 || c == 4) begin
        vectors++; if (Stage_Valid !== 4'b0111) begin miscompares++; $display("FAIL stall_valid c=%0d got=%b exp=0111", c, Stage_Valid); end
        vectors++; if (sd(2) !== 32'hA0) begin miscompares++; $display("FAIL stall_s2 c=%0d got=%h exp=a0", c, sd(2)); end
        vectors++; if (sd(0) !== 32'hA2) begin miscompares++; $display("FAIL stall_s0 c=%0d got=%h exp=a2", c, sd(0)); end
      end
    end
    Stall = '0; In_Valid = 1'b0; In_Data = '0;
    vectors++; if (got.size() !== 6) begin miscompares++; $display("FAIL stall_outcount got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      vectors++; if (got[i] !== 32'hA0 + 32'(i)) begin miscompares++; $display("FAIL stall_order i=%0d got=%h exp=%h", i, got[i], 32'hA0 + 32'(i)); end
    end
    vectors++; if (Bubble_Count !== 16'd2) begin miscompares++; $display("FAIL stall_bubble got=%0d exp=2", Bubble_Count); end
    vectors++; if (Retire_Count !== 16'd6) begin miscompares++; $display("FAIL stall_retire got=%0d exp=6", Retire_Count); end
  endtask

  task automatic test_flush_priority;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      In_Valid = 1'b1; In_Data = 32'h101 + 32'(i);
      tick();
    end
    Stall = 4'b0010; Flush = 4'b0010; In_Valid = 1'b1; In_Data = 32'h104;
    #1;
    vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got=%b exp=0", In_Ready); end
    tick();
    Stall = '0; Flush = '0; In_Valid = 1'b0; In_Data = '0;
    vectors++; if (Stage_Valid !== 4'b1101) begin miscompares++; $display("FAIL flush_valid got=%b exp=1101", Stage_Valid); end
    vectors++; if (sd(0) !== 32'h103) begin miscompares++; $display("FAIL flush_s0 got=%h exp=103", sd(0)); end
    vectors++; if (sd(1) !== 32'h0) begin miscompares++; $display("FAIL flush_s1 got=%h exp=0", sd(1)); end
    vectors++; if (sd(2) !== 32'h102) begin miscompares++; $display("FAIL flush_s2 got=%h exp=102", sd(2)); end
    vectors++; if (sd(3) !== 32'h101) begin miscompares++; $display("FAIL flush_s3 got=%h exp=101", sd(3)); end
    vectors++; if (Bubble_Count !== 16'd0) begin miscompares++; $display("FAIL flush_bubble got=%0d exp=0", Bubble_Count); end
  endtask

  task automatic test_input_discard;
    do_reset();
    In_Valid = 1'b1; In_Data = 32'hDEAD; Flush = 4'b0001;
    tick();
    In_Valid = 1'b0; In_Data = '0; Flush = '0;
    vectors++; if (Stage_Valid[0] !== 1'b0) begin miscompares++; $display("FAIL discard_valid got=%b exp=0", Stage_Valid[0]); end
    vectors++; if (sd(0) !== 32'h0) begin miscompares++; $display("FAIL discard_data got=%h exp=0", sd(0)); end
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++; if (Out_Valid !== 1'b0 || Out_Data === 32'hDEAD) begin miscompares++; $display("FAIL discard_out c=%0d got=%b/%h exp=0/not-dead", c, Out_Valid, Out_Data); end
    end
    vectors++; if (Retire_Count !== 16'd0) begin miscompares++; $display("FAIL discard_retire got=%0d exp=0", Retire_Count); end
  endtask

  task automatic test_saturation;
    int exp_r;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0;
    tick();
    s_rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      s_in_valid = (e <= 10);
      s_in_data  = 32'(e);
      tick();
      exp_r = (e - 4 < 0) ? 0 : ((e - 4 > 10) ? 10 : e - 4);
      if (exp_r > 7) exp_r = 7;
      vectors++; if (s_retire !== 3'(exp_r)) begin miscompares++; $display("FAIL sat_retire e=%0d got=%0d exp=%0d", e, s_retire, exp_r); end
    end
    s_in_valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Stall = '0; Flush = '0; In_Valid = 1'b0; In_Data = '0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0;
    tick();
    s_rst = 1'b0;
    test_reset();
    test_stream();
    test_mid_stall();
    test_flush_priority();
    test_input_discard();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised pipeline-register chain: the generalised successor to the fixed inter-stage registers of the pipelined CPU (F/D/E/M/W).
- DEPTH stages of WIDTH-bit payload, each with a valid bit.
- Per-stage stall and flush, with stalls propagating upstream and bubbles inserted downstream.
- Exposes every stage's contents as taps for forwarding muxes, plus retire and bubble counters for bench-level performance checks.

Parameters:
- WIDTH, 32, payload width per stage.
- DEPTH, 4, number of stages (>=2); stage 0 is nearest the input.
- CNT_W, 16, width of the saturating retire and bubble counters.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- In_Valid  in  1  input payload valid.
- In_Data  in  WIDTH  input payload.
- In_Ready  out  1  chain can accept input this cycle.
- Stall  in  DEPTH  bit k holds stage k.
- Flush  in  DEPTH  bit k kills stage k's next content.
- Stage_Valid  out  DEPTH  valid bit of each stage register.
- Stage_Data  out  DEPTH*WIDTH  stage k payload at bits [k*WIDTH +: WIDTH].
- Out_Valid  out  1  equals Stage_Valid[DEPTH-1].
- Out_Data  out  WIDTH  equals stage DEPTH-1 payload.
- Retire_Count  out  CNT_W  saturating count of retired entries.
- Bubble_Count  out  CNT_W  saturating count of cycles with at least one bubble inserted.

Behaviour:
- Reset: Rst=1 at an edge clears all stage valids, stage data and both counters to 0, regardless of Stall/Flush/In_Valid. Reset mid-stream discards all contents. In_Ready is combinational and may read 1 during reset.
- Hold: hold[k] = OR of Stall[j] for j>=k. A stall freezes its own stage and every upstream stage.
- In_Ready = ~hold[0].
- Per-stage update at each edge, in priority order:
  1. Rst: clear.
  2. Flush[k]: valid<=0, data<=0. Flush beats stall.
  3. hold[k]: keep contents.
  4. k>0 and hold[k-1] (i.e. Stall[k-1] with stage k free): bubble, valid<=0, data<=0.
  5. Otherwise load from stage k-1. For k=0, load valid<=In_Valid and data<=In_Data.
- A flush of stage k-1 does not affect what stage k loads that same edge; stage k takes pre-edge k-1 contents.
- Input is discarded (not back-pressured) when Flush[0]=1 and In_Ready=1.
- Stage 0 loads In_Data even when In_Valid=0; valid alone qualifies the entry.
- Latency: with no stalls or flushes, an entry accepted at edge n appears on Out_* after edge n+DEPTH-1 (DEPTH stage registers). Throughput is 1 per cycle.
- Retire: one event per edge where Out_Valid=1 and Stall[DEPTH-1]=0 and Rst=0. Retire_Count increments by 1, saturating at 2^CNT_W-1 (no wrap).
- Bubble_Count: increments by 1 per edge where case 4 fires in any stage k>0 and that stage is not flushed; saturates likewise.
- Simultaneous stall on several stages: the most downstream stall determines hold. Bubbles are inserted only at the boundary below the lowest held stage, never inside a held region.
- All outputs are registered except In_Ready.

Test Plan:
- Reset: DEPTH=4, WIDTH=32. Preload 4 valid entries, assert Rst one cycle with Stall=4'b1111 -> all Stage_Valid=0, Stage_Data=0, counters=0 after the edge.
- Streaming: inject 0x11,0x22,0x33 on consecutive cycles, no stalls -> 0x11 on Out_Data exactly 3 edges after its accept, then 0x22 and 0x33 on consecutive cycles. Retire_Count=3, Bubble_Count=0.
- Mid stall: Stall=4'b0100 for 2 cycles with stream 0xA0..0xA5 -> stages 0-2 frozen and In_Ready=0 for 2 cycles. Stage 3 receives 2 bubbles, Bubble_Count=2. No payload lost or duplicated on output order.
- Flush priority: Stall=4'b0010 and Flush=4'b0010 on the same edge -> stage 1 valid=0. Stage 0 held with In_Ready=0. Stage 2 takes old stage-1 payload.
- Input discard: In_Valid=1, In_Data=0xDEAD, Flush=4'b0001 -> stage 0 invalid. 0xDEAD never appears on Out_Data, Retire_Count unchanged.
- Saturation: CNT_W=3, stream 10 valid entries -> Retire_Count reaches 7 and stays 7.
